// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: state encoding and defaults shared by the serial arithmetic blocks
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit full-subtractor cell built from gate primitives
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic xy, nx, nxy, t_borrow, t_prop;

    // d = x ^ y ^ bin
    xor g_xy (xy, x, y);
    xor g_d  (d, xy, bin);

    // bout = (~x & y) | (~(x ^ y) & bin)
    not g_nx  (nx, x);
    and g_t0  (t_borrow, nx, y);
    not g_nxy (nxy, xy);
    and g_t1  (t_prop, nxy, bin);
    or  g_out (bout, t_borrow, t_prop);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - borrow_in with start/busy/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int COUNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               brw_q, brw_d;
    logic               a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic               borrow_out_q, borrow_out_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;
    logic               cell_d, cell_b, last;
    logic [WIDTH-1:0]   res_full;

    full_subtractor u_cell (
        .x   (a_q[0]),
        .y   (b_q[0]),
        .bin (brw_q),
        .d   (cell_d),
        .bout(cell_b)
    );

    assign last     = cnt_q == COUNT_W'(WIDTH - 1);
    // new difference bit enters at the MSB while the partial result moves right
    assign res_full = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state: start only honoured in IDLE, DONE lasts a single cycle
    always_comb begin
        state_d = (state_q == IDLE && start)  ? SHIFT :
                  (state_q == SHIFT && last)  ? DONE  :
                  (state_q == DONE)           ? IDLE  : state_q;
    end

    // datapath registers: operands, borrow, counter, partial and held results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            brw_q        <= 1'b0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            brw_q        <= brw_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
            zero_q       <= zero_d;
        end
    end

    // datapath next values: load on accepted start, shift one bit per SHIFT cycle, publish on the last bit
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        brw_d        = brw_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;
        zero_d       = zero_q;
        if (state_q == IDLE && start) begin
            a_d     = a;
            b_d     = b;
            res_d   = '0;
            cnt_d   = '0;
            brw_d   = borrow_in;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end else if (state_q == SHIFT) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_full;
            cnt_d = cnt_q + 1'b1;
            brw_d = cell_b;
            if (last) begin
                diff_d       = res_full;
                borrow_out_d = cell_b;
                overflow_d   = (a_msb_q != b_msb_q) && (res_full[WIDTH-1] != a_msb_q);
                zero_d       = res_full == '0;
            end
        end
    end

    // outputs: handshake decoded from state, results straight from held registers
    always_comb begin
        busy       = state_q == SHIFT;
        done       = state_q == DONE;
        diff       = diff_q;
        borrow_out = borrow_out_q;
        overflow   = overflow_q;
        zero       = zero_q;
    end

endmodule
